// File: rtl/dbi_tx_phy.sv
// DBI type-B write PHY: sends a DCS command byte followed by a counted burst of data bytes.
// Optional feature macro DBI_TX_PHY_TIMEOUT_EN adds a data-starvation timeout in DAT_WAIT.
module dbi_tx_phy #(
    parameter int DBI_IF_D_W = 8,
    parameter int LEN_W      = 16,
    parameter int WR_LO_CYC  = 2,
    parameter int WR_HI_CYC  = 2,
    parameter int TMO_CYC    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DBI_IF_D_W-1:0] cmd_code_i,
    input  logic [LEN_W-1:0]      cmd_len_i,
    input  logic                  cmd_vld_i,
    output logic                  cmd_rdy_o,
    input  logic [DBI_IF_D_W-1:0] dtp_d_data_i,
    input  logic                  dtp_d_vld_i,
    output logic                  dtp_d_rdy_o,
    output logic                  dbi_csx_o,
    output logic                  dbi_dcx_o,
    output logic                  dbi_wrx_o,
    output logic [DBI_IF_D_W-1:0] dbi_d_o,
    output logic                  busy_o,
    output logic                  err_tmo_o
);

    typedef enum logic [2:0] {
        IDLE,
        CMD_LO,
        CMD_HI,
        DAT_WAIT,
        DAT_LO,
        DAT_HI,
        CS_END
    } state_t;

    localparam int CYC_MAX = (WR_LO_CYC > WR_HI_CYC) ? WR_LO_CYC : WR_HI_CYC;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);

    generate
        if (WR_LO_CYC < 1 || WR_HI_CYC < 1 || TMO_CYC < 1) begin : g_bad_param
            $error("dbi_tx_phy: WR_LO_CYC, WR_HI_CYC and TMO_CYC must all be >= 1");
        end
    endgenerate

    state_t           state;
    state_t           state_n;
    logic [CYC_W-1:0] cyc_cnt;
    logic [LEN_W-1:0] rem_cnt;
    logic             cmd_fire;
    logic             dat_fire;
    logic             lo_done;
    logic             hi_done;
    logic             tmo_hit;

    // Ready flags are masked by rst so nothing is accepted on a reset cycle.
    assign cmd_rdy_o   = (state == IDLE) && !rst;
    assign dtp_d_rdy_o = (state == DAT_WAIT) && !rst;
    assign busy_o      = (state != IDLE);

    assign cmd_fire = cmd_vld_i && cmd_rdy_o;
    assign dat_fire = dtp_d_vld_i && dtp_d_rdy_o;
    assign lo_done  = (cyc_cnt == CYC_W'(WR_LO_CYC - 1));
    assign hi_done  = (cyc_cnt == CYC_W'(WR_HI_CYC - 1));

`ifdef DBI_TX_PHY_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             err_q;

    // Counts consecutive DAT_WAIT cycles without a data handshake.
    assign tmo_hit   = (state == DAT_WAIT) && !dat_fire && (tmo_cnt == TMO_W'(TMO_CYC - 1));
    assign err_tmo_o = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= tmo_hit;
            if (state == DAT_WAIT && !dat_fire) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end else begin
                tmo_cnt <= '0;
            end
        end
    end
`else
    assign tmo_hit   = 1'b0;
    assign err_tmo_o = 1'b0;
`endif

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (cmd_fire) state_n = CMD_LO;
            end
            CMD_LO: begin
                if (lo_done) state_n = CMD_HI;
            end
            CMD_HI: begin
                if (hi_done) state_n = (rem_cnt == '0) ? CS_END : DAT_WAIT;
            end
            DAT_WAIT: begin
                if (dat_fire) begin
                    state_n = DAT_LO;
                end else if (tmo_hit) begin
                    state_n = CS_END;
                end
            end
            DAT_LO: begin
                if (lo_done) state_n = DAT_HI;
            end
            DAT_HI: begin
                if (hi_done) state_n = (rem_cnt == LEN_W'(1)) ? CS_END : DAT_WAIT;
            end
            CS_END: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cyc_cnt <= '0;
            rem_cnt <= '0;
        end else begin
            state <= state_n;

            // Strobe-phase counter restarts on every state change.
            if (state_n == state &&
                (state == CMD_LO || state == CMD_HI || state == DAT_LO || state == DAT_HI)) begin
                cyc_cnt <= cyc_cnt + CYC_W'(1);
            end else begin
                cyc_cnt <= '0;
            end

            if (cmd_fire) begin
                rem_cnt <= cmd_len_i;
            end else if (state == DAT_HI && hi_done) begin
                rem_cnt <= rem_cnt - LEN_W'(1);
            end
        end
    end

    // Pins are decoded from the next state so they change together with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            dbi_csx_o <= 1'b1;
            dbi_wrx_o <= 1'b1;
            dbi_dcx_o <= 1'b1;
            dbi_d_o   <= '0;
        end else begin
            unique case (state_n)
                IDLE: begin
                    dbi_csx_o <= 1'b1;
                    dbi_wrx_o <= 1'b1;
                    dbi_dcx_o <= 1'b1;
                end
                CMD_LO: begin
                    dbi_csx_o <= 1'b0;
                    dbi_wrx_o <= 1'b0;
                    dbi_dcx_o <= 1'b0;
                end
                CMD_HI: begin
                    dbi_csx_o <= 1'b0;
                    dbi_wrx_o <= 1'b1;
                    dbi_dcx_o <= 1'b0;
                end
                DAT_WAIT: begin
                    dbi_csx_o <= 1'b0;
                    dbi_wrx_o <= 1'b1;
                    dbi_dcx_o <= 1'b1;
                end
                DAT_LO: begin
                    dbi_csx_o <= 1'b0;
                    dbi_wrx_o <= 1'b0;
                    dbi_dcx_o <= 1'b1;
                end
                DAT_HI: begin
                    dbi_csx_o <= 1'b0;
                    dbi_wrx_o <= 1'b1;
                    dbi_dcx_o <= 1'b1;
                end
                CS_END: begin
                    dbi_csx_o <= 1'b1;
                    dbi_wrx_o <= 1'b1;
                end
                default: begin
                    dbi_csx_o <= 1'b1;
                    dbi_wrx_o <= 1'b1;
                    dbi_dcx_o <= 1'b1;
                end
            endcase

            // The bus register doubles as the command/data byte latch.
            if (cmd_fire) begin
                dbi_d_o <= cmd_code_i;
            end else if (dat_fire) begin
                dbi_d_o <= dtp_d_data_i;
            end
        end
    end

endmodule

// File: tb/tb_dbi_tx_phy.sv
// Testbench for dbi_tx_phy: table vectors, randomized transfers and multi-cycle corner sequences.
module tb_dbi_tx_phy;

`ifdef DBI_TX_PHY_TIMEOUT_EN
    localparam int TB_TMO = 16;
`else
    localparam int TB_TMO = 1024;
`endif
    localparam int LO = 2;
    localparam int HI = 2;

    logic        clk;
    logic        rst;
    logic [7:0]  cmd_code_i;
    logic [15:0] cmd_len_i;
    logic        cmd_vld_i;
    logic        cmd_rdy_o;
    logic [7:0]  dtp_d_data_i;
    logic        dtp_d_vld_i;
    logic        dtp_d_rdy_o;
    logic        dbi_csx_o;
    logic        dbi_dcx_o;
    logic        dbi_wrx_o;
    logic [7:0]  dbi_d_o;
    logic        busy_o;
    logic        err_tmo_o;

    int n_cmp  = 0;
    int n_fail = 0;
    int err_seen = 0;

    dbi_tx_phy #(
        .DBI_IF_D_W (8),
        .LEN_W      (16),
        .WR_LO_CYC  (LO),
        .WR_HI_CYC  (HI),
        .TMO_CYC    (TB_TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_code_i   (cmd_code_i),
        .cmd_len_i    (cmd_len_i),
        .cmd_vld_i    (cmd_vld_i),
        .cmd_rdy_o    (cmd_rdy_o),
        .dtp_d_data_i (dtp_d_data_i),
        .dtp_d_vld_i  (dtp_d_vld_i),
        .dtp_d_rdy_o  (dtp_d_rdy_o),
        .dbi_csx_o    (dbi_csx_o),
        .dbi_dcx_o    (dbi_dcx_o),
        .dbi_wrx_o    (dbi_wrx_o),
        .dbi_d_o      (dbi_d_o),
        .busy_o       (busy_o),
        .err_tmo_o    (err_tmo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err_tmo_o === 1'b1) err_seen = err_seen + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    // Waits (bounded) until the DUT offers cmd_rdy_o at a negedge; returns 0 on expiry.
    task automatic wait_cmd_rdy(output bit ok);
        int w = 0;
        while (cmd_rdy_o !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        ok = (cmd_rdy_o === 1'b1);
        if (!ok) chk("cmd_rdy_wait_expired", 0, 1);
    endtask

    // One full transfer; expected panel-side bytes and timing come from the protocol rules:
    // command byte then data bytes, csx low for LO+HI per command plus (1+LO+HI) per byte plus stall cycles.
    task automatic run_txn(input logic [7:0] code, input int len, input int gap_byte,
                           input int gap, input int exp_low);
        logic [7:0] bytes[$];
        logic [8:0] exp_q[$];
        logic [8:0] got_q[$];
        int idx, waited, low, falls, idle_t, ncmp;
        logic pw, pc;
        bit ok;
        bytes = {};
        exp_q = {};
        got_q = {};
        exp_q.push_back({1'b0, code});
        for (int i = 0; i < len; i++) begin
            bytes.push_back(8'($urandom));
            exp_q.push_back({1'b1, bytes[i]});
        end
        cmd_code_i  = code;
        cmd_len_i   = 16'(len);
        cmd_vld_i   = 1'b1;
        dtp_d_vld_i = 1'b1;
        dtp_d_data_i = 8'($urandom);
        wait_cmd_rdy(ok);
        if (!ok) begin
            cmd_vld_i = 1'b0;
            return;
        end
        pw = dbi_wrx_o;
        pc = dbi_csx_o;
        idx = 0; waited = 0; low = 0; falls = 0; idle_t = -1;
        for (int t = 1; t <= 400 && idle_t < 0; t++) begin
            @(negedge clk);
            if (t == 1) begin
                cmd_vld_i  = 1'b0;
                cmd_len_i  = 16'($urandom);
                cmd_code_i = 8'($urandom);
            end
            if (!pw && dbi_wrx_o) got_q.push_back({dbi_dcx_o, dbi_d_o});
            if (pc && !dbi_csx_o) falls++;
            if (!dbi_csx_o) low++;
            pw = dbi_wrx_o;
            pc = dbi_csx_o;
            if (cmd_rdy_o) idle_t = t;
            if (idx < len && idx == gap_byte && waited < gap) begin
                dtp_d_vld_i = 1'b0;
                if (dtp_d_rdy_o) waited++;
            end else begin
                dtp_d_vld_i  = 1'b1;
                dtp_d_data_i = (idx < len) ? bytes[idx] : 8'($urandom);
                if (dtp_d_rdy_o && idx < len) idx++;
            end
        end
        dtp_d_vld_i = 1'b0;
        chk("idle_after_hs", idle_t, exp_low + 2);
        chk("csx_low_cycles", low, exp_low);
        chk("csx_windows", falls, 1);
        chk("strobe_count", got_q.size(), exp_q.size());
        ncmp = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < ncmp; i++) chk("latched_dcx_d", int'(got_q[i]), int'(exp_q[i]));
        chk("idle_pins", int'({dbi_csx_o, dbi_wrx_o, dbi_dcx_o}), 7);
        chk("idle_d_hold", int'(dbi_d_o), int'(exp_q[exp_q.size() - 1][7:0]));
    endtask

    typedef struct {
        logic [7:0] code;
        int         len;
        int         gap_byte;
        int         gap;
        int         exp_low;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [7:0] b[3];
        logic pw, pc;
        int idx, falls, rises, len, gb, gp;
        bit ok;

        vecs[0] = '{8'h29, 0, -1, 0, 4};
        vecs[1] = '{8'h2C, 3, -1, 0, 19};
        vecs[2] = '{8'h2C, 3, 1, 10, 29};
        vecs[3] = '{8'h2A, 1, -1, 0, 9};
        vecs[4] = '{8'h3C, 2, 0, 3, 17};

        rst = 1'b1;
        cmd_code_i = '0; cmd_len_i = '0; cmd_vld_i = 1'b0;
        dtp_d_data_i = '0; dtp_d_vld_i = 1'b0;

        // Reset state, with vld inputs active to confirm nothing is accepted during rst.
        repeat (3) @(negedge clk);
        cmd_vld_i = 1'b1; dtp_d_vld_i = 1'b1;
        @(negedge clk);
        chk("rst_cmd_rdy", int'(cmd_rdy_o), 0);
        chk("rst_dtp_rdy", int'(dtp_d_rdy_o), 0);
        chk("rst_pins", int'({dbi_csx_o, dbi_wrx_o, dbi_dcx_o}), 7);
        chk("rst_d", int'(dbi_d_o), 0);
        chk("rst_busy_err", int'({busy_o, err_tmo_o}), 0);
        cmd_vld_i = 1'b0; dtp_d_vld_i = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_rdy", int'(cmd_rdy_o), 1);

        for (int v = 0; v < 5; v++) begin
            run_txn(vecs[v].code, vecs[v].len, vecs[v].gap_byte, vecs[v].gap, vecs[v].exp_low);
            @(negedge clk);
        end

        for (int r = 0; r < 20; r++) begin
            len = int'($urandom_range(0, 4));
            gb  = int'($urandom_range(0, 3));
            gp  = int'($urandom_range(0, 6));
            run_txn(8'($urandom), len, gb, gp,
                    (LO + HI) + len * (1 + LO + HI) + ((gb < len) ? gp : 0));
            repeat (int'($urandom_range(0, 2))) @(negedge clk);
        end

        // Reset in DAT_LO of the second data byte, then a clean transfer.
        for (int i = 0; i < 3; i++) b[i] = 8'($urandom);
        cmd_code_i = 8'h2C; cmd_len_i = 16'd3; cmd_vld_i = 1'b1;
        wait_cmd_rdy(ok);
        idx = 0;
        for (int t = 1; t <= 11 && ok; t++) begin
            @(negedge clk);
            cmd_vld_i = 1'b0;
            dtp_d_vld_i = 1'b1;
            dtp_d_data_i = b[idx];
            if (dtp_d_rdy_o && idx < 2) idx++;
        end
        chk("abort_in_dat_lo", int'({dbi_csx_o, dbi_wrx_o, dbi_dcx_o}), 1);
        chk("abort_byte2_on_bus", int'(dbi_d_o), int'(b[1]));
        rst = 1'b1;
        dtp_d_vld_i = 1'b0;
        @(negedge clk);
        chk("abort_pins_next", int'({dbi_csx_o, dbi_wrx_o}), 3);
        chk("abort_busy", int'(busy_o), 0);
        chk("abort_cmd_rdy_masked", int'(cmd_rdy_o), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_cmd_rdy", int'(cmd_rdy_o), 1);
        chk("abort_csx_high", int'(dbi_csx_o), 1);
        run_txn(8'h2C, 3, -1, 0, 19);
        @(negedge clk);

        // Back-to-back commands with cmd_vld_i held high.
        cmd_code_i = 8'h11; cmd_len_i = 16'd0; cmd_vld_i = 1'b1;
        wait_cmd_rdy(ok);
        pw = dbi_wrx_o; pc = dbi_csx_o; falls = 0; rises = 0;
        for (int t = 1; t <= 18 && ok; t++) begin
            @(negedge clk);
            if (pc && !dbi_csx_o) falls++;
            if (!pw && dbi_wrx_o) begin
                rises++;
                chk("b2b_latched", int'({dbi_dcx_o, dbi_d_o}), 9'h011);
            end
            if (t == 5 || t == 6) chk("b2b_csx_gap", int'(dbi_csx_o), 1);
            if (t == 18) chk("b2b_idle", int'(cmd_rdy_o), 1);
            pw = dbi_wrx_o; pc = dbi_csx_o;
            if (t == 17) cmd_vld_i = 1'b0;
        end
        cmd_vld_i = 1'b0;
        chk("b2b_windows", falls, 3);
        chk("b2b_strobes", rises, 3);
        @(negedge clk);

`ifdef DBI_TX_PHY_TIMEOUT_EN
        // Starve the data side after one byte of four.
        begin
            int err_t, err_n, idle_t2;
            bit got_one;
            err_t = -1; err_n = 0; idle_t2 = -1; got_one = 1'b0;
            cmd_code_i = 8'h2C; cmd_len_i = 16'd4; cmd_vld_i = 1'b1;
            wait_cmd_rdy(ok);
            for (int t = 1; t <= 60 && idle_t2 < 0 && ok; t++) begin
                @(negedge clk);
                cmd_vld_i = 1'b0;
                if (err_tmo_o) begin
                    err_n++;
                    err_t = t;
                    chk("tmo_csx_rise", int'(dbi_csx_o), 1);
                end
                if (cmd_rdy_o) idle_t2 = t;
                dtp_d_vld_i = !got_one;
                dtp_d_data_i = 8'h5A;
                if (dtp_d_rdy_o && !got_one) got_one = 1'b1;
            end
            dtp_d_vld_i = 1'b0;
            chk("tmo_pulse_count", err_n, 1);
            chk("tmo_pulse_cycle", err_t, 1 + (LO + HI) + (1 + LO + HI) + TB_TMO);
            chk("tmo_idle_cycle", idle_t2, 2 + (LO + HI) + (1 + LO + HI) + TB_TMO);
            @(negedge clk);
        end
        chk("err_tmo_total", err_seen, 1);
`else
        chk("err_tmo_total", err_seen, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
